// File: rtl/text_string_map.sv
// -----------------------------------------------------------------------------
// text_string_map
//
// Maps a pixel position inside a short text string to a single glyph pixel.
// A small character buffer holds one {glyph code, blink} entry per character
// slot. Each pixel request runs through a fixed three-stage pipeline:
//   S0 : register the request and split X into slot / column
//   S1 : read the buffer (with write bypass) and drive the font ROM address
//   S2 : capture the ROM row and pick out the requested pixel
// Lookups are fully pipelined: one request per cycle, no stalls, and
// pixel_valid follows req_valid by exactly three cycles.
//
// Optional feature (macro TEXT_BLINK_EN):
//   When defined, a frame counter advances on frame_start and toggles a blink
//   phase every BLINK_FRAMES frames. While the phase is 1, pixels from slots
//   whose blink attribute is set read as 0. When undefined, wr_blink and
//   frame_start are ignored and no blink state exists.
//
// Ports
//   Clk          : sole clock, rising edge
//   Reset_n      : synchronous, active-low reset
//   wr_en        : character buffer write strobe
//   wr_idx       : slot to write (writes to slots >= NUM_CHARS are dropped)
//   wr_code      : glyph code to write
//   wr_blink     : blink attribute to write
//   frame_start  : one-cycle pulse per video frame
//   req_valid    : pixel lookup request
//   X            : pixel column within the string
//   Y            : pixel row within the glyph (0-15)
//   rom_address  : font ROM address, code*16 + Y (holds when S1 is idle)
//   rom_data     : font ROM row, one cycle after rom_address; bit 7 = leftmost
//   pixel_valid  : marks a valid pixel result
//   pixel        : glyph pixel, 1 = foreground (0 whenever pixel_valid is 0)
// -----------------------------------------------------------------------------
module text_string_map #(
  parameter int NUM_CHARS    = 8,
  parameter int NUM_GLYPHS   = 16,
  parameter int BLINK_FRAMES = 30,
  localparam int XW = $clog2(NUM_CHARS * 8),
  localparam int IW = $clog2(NUM_CHARS),
  localparam int CW = $clog2(NUM_GLYPHS)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [CW-1:0] wr_code,
  input  logic          wr_blink,
  input  logic          frame_start,
  input  logic          req_valid,
  input  logic [XW-1:0] X,
  input  logic [3:0]    Y,
  output logic [CW+3:0] rom_address,
  input  logic [7:0]    rom_data,
  output logic          pixel_valid,
  output logic          pixel
);

  // One extra bit so NUM_CHARS itself is representable for range compares.
  localparam logic [IW:0] NUM_CHARS_W = (IW+1)'(NUM_CHARS);

  // ---------------------------------------------------------------------------
  // Character buffer (glyph codes)
  // ---------------------------------------------------------------------------
  logic [CW-1:0] buf_code_q [NUM_CHARS];
  logic [CW-1:0] buf_code_d [NUM_CHARS];
  logic          wr_in_range;

  assign wr_in_range = ({1'b0, wr_idx} < NUM_CHARS_W);

  always_comb begin
    buf_code_d = buf_code_q;
    if (wr_en && wr_in_range) begin
      buf_code_d[wr_idx] = wr_code;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        buf_code_q[i] <= '0;
      end
    end else begin
      buf_code_q <= buf_code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic          vld_p0_q, vld_p0_d;
  logic [IW-1:0] slot_p0_q, slot_p0_d;
  logic [2:0]    col_p0_q, col_p0_d;
  logic [3:0]    y_p0_q, y_p0_d;
  logic          oor_p0_q, oor_p0_d;

  logic          vld_p1_q, vld_p1_d;
  logic [2:0]    col_p1_q, col_p1_d;
  logic          oor_p1_q, oor_p1_d;

  logic          pixel_valid_q, pixel_valid_d;
  logic          pixel_q, pixel_d;

  logic [CW+3:0] addr_hold_q, addr_hold_d;
  logic [CW-1:0] rd_code;
  logic          blank;

  // S0: split the request into slot / column and flag slots past the string.
  always_comb begin
    vld_p0_d  = req_valid;
    slot_p0_d = X[XW-1:3];
    col_p0_d  = X[2:0];
    y_p0_d    = Y;
    oor_p0_d  = ({1'b0, X[XW-1:3]} >= NUM_CHARS_W);
  end

  // S1: buffer read. A write landing on the slot being read this cycle wins,
  // so software can update a character without a one-frame glitch.
  always_comb begin
    rd_code = '0;
    if (!oor_p0_q) begin
      rd_code = buf_code_q[slot_p0_q];
      if (wr_en && (wr_idx == slot_p0_q)) begin
        rd_code = wr_code;
      end
    end
  end

  // The ROM address is live in S1 and parks on its last value otherwise,
  // which keeps the ROM input quiet between bursts of requests.
  always_comb begin
    rom_address = vld_p0_q ? {rd_code, y_p0_q} : addr_hold_q;
    addr_hold_d = rom_address;
    vld_p1_d    = vld_p0_q;
    col_p1_d    = col_p0_q;
    oor_p1_d    = oor_p0_q;
  end

  // S2: rom_data now holds the row addressed in S1; bit 7 is column 0.
  always_comb begin
    pixel_valid_d = vld_p1_q;
    pixel_d       = vld_p1_q & ~oor_p1_q & ~blank & rom_data[3'd7 - col_p1_q];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vld_p0_q      <= 1'b0;
      vld_p1_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_q       <= 1'b0;
      addr_hold_q   <= '0;
    end else begin
      vld_p0_q      <= vld_p0_d;
      vld_p1_q      <= vld_p1_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_q       <= pixel_d;
      addr_hold_q   <= addr_hold_d;
    end
  end

  // Data-only pipeline fields: their meaning is qualified by the valids.
  always_ff @(posedge Clk) begin
    slot_p0_q <= slot_p0_d;
    col_p0_q  <= col_p0_d;
    y_p0_q    <= y_p0_d;
    oor_p0_q  <= oor_p0_d;
    col_p1_q  <= col_p1_d;
    oor_p1_q  <= oor_p1_d;
  end

  assign pixel_valid = pixel_valid_q;
  assign pixel       = pixel_q;

`ifdef TEXT_BLINK_EN
  // ---------------------------------------------------------------------------
  // Blink attribute store, frame counter and blink phase
  // ---------------------------------------------------------------------------
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic          buf_blink_q [NUM_CHARS];
  logic          buf_blink_d [NUM_CHARS];
  logic          rd_blink;
  logic          blink_p1_q, blink_p1_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    buf_blink_d = buf_blink_q;
    if (wr_en && wr_in_range) begin
      buf_blink_d[wr_idx] = wr_blink;
    end
  end

  // Same bypass rule as the glyph code so code and attribute stay paired.
  always_comb begin
    rd_blink = 1'b0;
    if (!oor_p0_q) begin
      rd_blink = buf_blink_q[slot_p0_q];
      if (wr_en && (wr_idx == slot_p0_q)) begin
        rd_blink = wr_blink;
      end
    end
    blink_p1_d = rd_blink;
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (frame_start) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        buf_blink_q[i] <= 1'b0;
      end
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      buf_blink_q <= buf_blink_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_ff @(posedge Clk) begin
    blink_p1_q <= blink_p1_d;
  end

  assign blank = blink_p1_q & phase_q;
`else
  // Blink support compiled out: attribute and frame pulses have no effect.
  logic unused_blink_inputs;
  assign unused_blink_inputs = wr_blink ^ frame_start;
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_text_string_map.sv
module tb_text_string_map;
  localparam int NC = 5;
  localparam int NG = 16;
  localparam int BF = 2;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [3:0] wr_code;
  logic       wr_blink;
  logic       frame_start;
  logic       req_valid;
  logic [5:0] X;
  logic [3:0] Y;
  logic [7:0] rom_address;
  logic [7:0] rom_data;
  logic       pixel_valid;
  logic       pixel;

  text_string_map #(.NUM_CHARS(NC), .NUM_GLYPHS(NG), .BLINK_FRAMES(BF)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_code(wr_code), .wr_blink(wr_blink), .frame_start(frame_start),
    .req_valid(req_valid), .X(X), .Y(Y), .rom_address(rom_address),
    .rom_data(rom_data), .pixel_valid(pixel_valid), .pixel(pixel)
  );

  always #5 Clk = ~Clk;

  // Synchronous font ROM, one-cycle read latency.
  logic [7:0] rom_mem [256];
  always @(posedge Clk) rom_data <= rom_mem[rom_address];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: buffer contents, request in S1, result one stage
  // from the output, and the expected output of the current cycle.
  typedef struct { bit v; bit oor; int slot; int col; int y; } req_t;
  typedef struct { bit v; bit oor; bit raw; bit blink; } mid_t;

  int   m_code  [8];
  bit   m_blink [8];
  req_t s1;
  mid_t mid;
  bit   out_v, out_p;
  int   last_addr;
  bit   addr_known;
  int   fcnt;
  bit   phase;

  task automatic reset_model();
    for (int i = 0; i < 8; i++) begin
      m_code[i]  = 0;
      m_blink[i] = 0;
    end
    s1 = '{0, 0, 0, 0, 0};
    mid = '{0, 0, 0, 0};
    out_v = 0;
    out_p = 0;
    last_addr = 0;
    addr_known = 1;
    fcnt = 0;
    phase = 0;
  endtask

  task automatic run_cycle(input bit rst_n, input bit we, input int widx, input int wcode,
                           input bit wblk, input bit fs, input bit rv, input int x, input int y);
    int   code;
    bit   blk;
    int   addr;
    mid_t n_mid;
    bit   n_out_v, n_out_p;
    Reset_n     = rst_n;
    wr_en       = we;
    wr_idx      = widx[2:0];
    wr_code     = wcode[3:0];
    wr_blink    = wblk;
    frame_start = fs;
    req_valid   = rv;
    X           = x[5:0];
    Y           = y[3:0];
    @(negedge Clk);
    check("pixel_valid", pixel_valid, out_v);
    check("pixel", pixel, out_p);
    n_mid = '{0, 0, 0, 0};
    if (s1.v) begin
      if (s1.oor) begin
        addr_known = 0;
        n_mid = '{1, 1, 0, 0};
      end else begin
        code = (we && widx == s1.slot) ? wcode : m_code[s1.slot];
        blk  = (we && widx == s1.slot) ? wblk : m_blink[s1.slot];
        addr = code * 16 + s1.y;
        check("rom_address", rom_address, addr);
        last_addr  = addr;
        addr_known = 1;
        n_mid = '{1, 0, rom_mem[addr][7 - s1.col], blk};
      end
    end else if (addr_known) begin
      check("rom_hold", rom_address, last_addr);
    end
    n_out_v = mid.v;
    n_out_p = mid.v && !mid.oor && mid.raw && !(mid.blink && phase);
    @(posedge Clk);
    if (!rst_n) begin
      reset_model();
    end else begin
      out_v = n_out_v;
      out_p = n_out_p;
      mid   = n_mid;
      s1    = '{rv, (x / 8) >= NC, x / 8, x % 8, y};
      if (we && widx < NC) begin
        m_code[widx] = wcode;
`ifdef TEXT_BLINK_EN
        m_blink[widx] = wblk;
`endif
      end
`ifdef TEXT_BLINK_EN
      if (fs) begin
        if (fcnt == BF - 1) begin
          fcnt  = 0;
          phase = !phase;
        end else begin
          fcnt++;
        end
      end
`endif
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic req(input int x, input int y);
    run_cycle(1, 0, 0, 0, 0, 0, 1, x, y);
  endtask

  task automatic wr(input int idx, input int code, input bit blk);
    run_cycle(1, 1, idx, code, blk, 0, 0, 0, 0);
  endtask

  task automatic pulse_frame();
    run_cycle(1, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic scan_slots01(input int y);
    for (int x = 0; x < 16; x++) req(x, y);
    idle(4);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'h00;  // glyph 0 is blank
    rom_mem[83] = 8'b0100_0000;
    rom_mem[3*16 + 6] = 8'b1011_0110;
    rom_mem[4*16 + 6] = 8'b0110_1101;

    Reset_n = 0; wr_en = 0; wr_idx = 0; wr_code = 0; wr_blink = 0;
    frame_start = 0; req_valid = 0; X = 0; Y = 0;
    repeat (2) @(posedge Clk);
    #1;
    reset_model();

    // Reset state, then first lookup of blank glyph 0.
    idle(1);
    req(0, 0);
    idle(4);

    // Slot 2 = code 5, X=17 (slot 2, col 1), Y=3 -> address 83, pixel 1.
    wr(2, 5, 0);
    req(17, 3);
    idle(4);

    // Back-to-back requests across slot 0.
    wr(0, 7, 0);
    for (int x = 0; x < 8; x++) req(x, 2);
    idle(4);

    // Slots past NUM_CHARS read as 0 but still produce pixel_valid.
    req(40, 5);
    req(63, 0);
    req(17, 3);
    idle(4);

    // Dropped write to a non-existent slot.
    wr(6, 9, 1);
    req(17, 3);
    idle(4);

    // Write bypass: slot 1 rewritten in the cycle its request is in S1.
    req(8, 1);
    run_cycle(1, 1, 1, 11, 0, 0, 0, 0, 0);
    idle(3);
    req(9, 1);
    idle(4);

    // Reset in mid-pipeline discards in-flight requests.
    req(17, 3);
    req(18, 3);
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Blink: slot 0 blinking, slot 1 steady.
    wr(0, 3, 1);
    wr(1, 4, 0);
    scan_slots01(6);
    pulse_frame();
    idle(1);
    pulse_frame();
    idle(1);
    scan_slots01(6);
    pulse_frame();
    pulse_frame();
    idle(1);
    scan_slots01(6);

    // Randomized traffic with occasional resets and frame pulses.
    for (int i = 0; i < 2000; i++) begin
      run_cycle(($urandom_range(0, 199) != 0),
                ($urandom_range(0, 9) < 3), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 15)), 1'($urandom),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
                int'($urandom_range(0, 63)), int'($urandom_range(0, 15)));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
